sample_cache: RTL and testbench

Upstream neighbour of the main control FSM. Sits between the sampler and the capture memory. Takes one 32-bit sample per stb_i and keeps only the bytes of the active channel groups. It packs those bytes densely into 32-bit memory words and pulses cstb_o each time a full word is ready. Bytes that do not yet fill a word stay in the cache and are exposed for the control FSM's cache readback.

---
 rtl/sample_cache.sv | 107 ++++++++++
 tb/tb_sample_cache.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sample_cache.sv
// sample_cache: packs the bytes of the active channel groups from each
// accepted 32-bit sample into dense 32-bit memory words. A full word is
// presented on cdata_o with a one-cycle cstb_o pulse. Leftover bytes (0..3)
// stay in a small cache that is visible on cache_o/cnt_o for readback.
module sample_cache #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             stb_i,
   input  logic [WIDTH-1:0] smpl_i,
   input  logic [3:0]       cfg_i,
   output logic             cstb_o,
   output logic [WIDTH-1:0] cdata_o,
   output logic [1:0]       cnt_o,
   output logic [23:0]      cache_o
);

   logic             cstb_q, cstb_d;
   logic [WIDTH-1:0] cdata_q, cdata_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [23:0]      cache_q, cache_d;

   logic [31:0]      kept;      // active group bytes, compacted to the bottom
   logic [2:0]       n_kept;    // number of active groups (0..4)
   logic [55:0]      strm;      // cached bytes followed by kept bytes, zero-filled
   logic [55:0]      cache_ext; // cache widened so every stream lane has a source
   logic [2:0]       total;     // bytes in the stream (0..7)
   logic             accept;

   assign accept    = en_i & stb_i & ~clr_i;
   assign cache_ext = {32'b0, cache_q};
   assign total     = {1'b0, cnt_q} + n_kept;

   // Compact the active groups: each kept byte lands at the running count of
   // active groups below it (prefix popcount of cfg_i).
   always_comb begin
      logic [2:0] acc;
      acc  = '0;
      kept = '0;
      for (int g = 0; g < 4; g++) begin
         if (cfg_i[g]) begin
            kept[8*acc[1:0] +: 8] = smpl_i[8*g +: 8];
            acc = acc + 3'd1;
         end
      end
      n_kept = acc;
   end

   // Byte-lane mux: lanes below cnt_q come from the cache, the next n_kept
   // lanes from the compacted sample, everything past the end reads zero.
   always_comb begin
      strm = '0;
      for (int i = 0; i < 7; i++) begin
         if (i < int'(cnt_q)) begin
            strm[8*i +: 8] = cache_ext[8*i +: 8];
         end else if ((i - int'(cnt_q)) < int'(n_kept)) begin
            strm[8*i +: 8] = kept[8*(i - int'(cnt_q)) +: 8];
         end
      end
   end

   // Next-state: clear beats accept; a full stream emits its first four bytes
   // and keeps the rest. The low two bits of total are the new count either way.
   always_comb begin
      cstb_d  = 1'b0;
      cdata_d = cdata_q;
      cnt_d   = cnt_q;
      cache_d = cache_q;
      if (clr_i) begin
         cnt_d   = '0;
         cache_d = '0;
      end else if (accept) begin
         cnt_d = total[1:0];
         if (total[2]) begin
            cstb_d  = 1'b1;
            cdata_d = strm[31:0];
            cache_d = strm[55:32];
         end else begin
            cache_d = strm[23:0];
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cstb_q  <= 1'b0;
         cdata_q <= '0;
         cnt_q   <= '0;
         cache_q <= '0;
      end else begin
         cstb_q  <= cstb_d;
         cdata_q <= cdata_d;
         cnt_q   <= cnt_d;
         cache_q <= cache_d;
      end
   end

   assign cstb_o  = cstb_q;
   assign cdata_o = cdata_q;
   assign cnt_o   = cnt_q;
   assign cache_o = cache_q;

endmodule

// File: tb/tb_sample_cache.sv
// Directed testbench for sample_cache with hand-computed expected values.
module tb_sample_cache;

   logic        clk_i = 1'b0;
   logic        rst_i, en_i, clr_i, stb_i;
   logic [31:0] smpl_i;
   logic [3:0]  cfg_i;
   logic        cstb_o;
   logic [31:0] cdata_o;
   logic [1:0]  cnt_o;
   logic [23:0] cache_o;

   int checks = 0;
   int errors = 0;

   sample_cache #(.WIDTH(32)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .clr_i   (clr_i),
      .stb_i   (stb_i),
      .smpl_i  (smpl_i),
      .cfg_i   (cfg_i),
      .cstb_o  (cstb_o),
      .cdata_o (cdata_o),
      .cnt_o   (cnt_o),
      .cache_o (cache_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Advance one clock edge and settle, so outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Check all four outputs in one go.
   task automatic chk_all(input string tag, input logic cs, input logic [31:0] cd,
                          input logic [1:0] cn, input logic [23:0] ca);
      chk({tag, ".cstb"},  {31'b0, cstb_o}, {31'b0, cs});
      chk({tag, ".cdata"}, cdata_o, cd);
      chk({tag, ".cnt"},   {30'b0, cnt_o}, {30'b0, cn});
      chk({tag, ".cache"}, {8'b0, cache_o}, {8'b0, ca});
   endtask

   task automatic sample(input logic [3:0] cfg, input logic [31:0] s);
      cfg_i  = cfg;
      smpl_i = s;
      stb_i  = 1'b1;
      step();
   endtask

   initial begin
      rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; stb_i = 1'b0;
      smpl_i = 32'h0; cfg_i = 4'h0;
      #1;
      step();
      step();
      chk_all("reset", 1'b0, 32'h0, 2'd0, 24'h0);
      rst_i = 1'b0; en_i = 1'b1;

      // 1: all groups active, every sample is a full word
      sample(4'b1111, 32'h44332211);
      chk_all("t1.s0", 1'b1, 32'h44332211, 2'd0, 24'h0);
      sample(4'b1111, 32'h88776655);
      chk_all("t1.s1", 1'b1, 32'h88776655, 2'd0, 24'h0);
      stb_i = 1'b0;
      step();
      chk_all("t1.idle", 1'b0, 32'h88776655, 2'd0, 24'h0);

      // 2: one group, four samples build one word
      sample(4'b0001, 32'hFFFFFFA1);
      chk_all("t2.s0", 1'b0, 32'h88776655, 2'd1, 24'h0000A1);
      sample(4'b0001, 32'hFFFFFFA2);
      chk_all("t2.s1", 1'b0, 32'h88776655, 2'd2, 24'h00A2A1);
      sample(4'b0001, 32'hFFFFFFA3);
      chk_all("t2.s2", 1'b0, 32'h88776655, 2'd3, 24'hA3A2A1);
      sample(4'b0001, 32'hFFFFFFA4);
      chk_all("t2.s3", 1'b1, 32'hA4A3A2A1, 2'd0, 24'h0);

      // 3: three groups, word straddles two samples
      sample(4'b0111, 32'h00CCBBAA);
      chk_all("t3.s0", 1'b0, 32'hA4A3A2A1, 2'd3, 24'hCCBBAA);
      sample(4'b0111, 32'h00FFEEDD);
      chk_all("t3.s1", 1'b1, 32'hDDCCBBAA, 2'd2, 24'h00FFEE);

      // 4: non-contiguous mask with a full cache, then mask change
      stb_i = 1'b0; clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      sample(4'b0111, 32'h00CCBBAA);
      chk_all("t4.fill", 1'b0, 32'hDDCCBBAA, 2'd3, 24'hCCBBAA);
      sample(4'b0101, 32'h00330011);
      chk_all("t4.s0", 1'b1, 32'h11CCBBAA, 2'd1, 24'h000033);
      sample(4'b1000, 32'h99000000);
      chk_all("t4.s1", 1'b0, 32'h11CCBBAA, 2'd2, 24'h009933);

      // 5: clear wins over a simultaneous strobe
      clr_i = 1'b1;
      sample(4'b1111, 32'h12345678);
      chk_all("t5.clr", 1'b0, 32'h11CCBBAA, 2'd0, 24'h0);
      clr_i = 1'b0;
      sample(4'b0001, 32'h0000005A);
      chk_all("t5.one", 1'b0, 32'h11CCBBAA, 2'd1, 24'h00005A);
      en_i = 1'b0;
      sample(4'b1111, 32'hFFFFFFFF);
      sample(4'b1111, 32'hFFFFFFFF);
      chk_all("t5.dis", 1'b0, 32'h11CCBBAA, 2'd1, 24'h00005A);
      en_i = 1'b1;
      sample(4'b0000, 32'hEEEEEEEE);
      chk_all("t5.cfg0", 1'b0, 32'h11CCBBAA, 2'd1, 24'h00005A);
      sample(4'b0111, 32'h00030201);
      chk_all("t5.reen", 1'b1, 32'h0302015A, 2'd0, 24'h0);

      // 6: reset in the middle of a continuous stream
      sample(4'b0001, 32'h000000AB);
      chk_all("t6.part", 1'b0, 32'h0302015A, 2'd1, 24'h0000AB);
      sample(4'b1111, 32'h11111111);
      chk_all("t6.s0", 1'b1, 32'h111111AB, 2'd1, 24'h000011);
      rst_i = 1'b1;
      sample(4'b1111, 32'h22222222);
      chk_all("t6.rst", 1'b0, 32'h0, 2'd0, 24'h0);
      rst_i = 1'b0;
      sample(4'b1111, 32'h33333333);
      chk_all("t6.s1", 1'b1, 32'h33333333, 2'd0, 24'h0);
      stb_i = 1'b0;
      step();
      chk_all("t6.end", 1'b0, 32'h33333333, 2'd0, 24'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
